uart_rx_ctl_param: RTL and testbench
====================================

Name: uart_rx_ctl_param

Overview:
Parametrised UART receive controller; next generation of the team's 8N1 RX controller.
Takes the already-synchronised RXD bit and a per-bit oversampling tick, and deframes one character at a time.
Frame format is configurable: 5-9 data bits, none/even/odd parity, 1 or 2 stop bits.
Reports data plus separate parity and framing error flags. Sits between the RXD synchroniser/baud generator and the RX FIFO.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9, sent LSB first
OVERSAMPLE, 16, i_baud_en ticks per bit period, even, legal 8..32
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd; 3 is illegal and is rejected at elaboration
STOP_BITS, 1, number of stop bits checked, legal 1 or 2

Ports:
i_clk  input  1  system clock; all logic on rising edge
i_rst  input  1  asynchronous active-low reset
i_baud_en  input  1  oversampling tick, one i_clk cycle wide, OVERSAMPLE per bit
i_rx  input  1  RXD, already synchronised to i_clk, idle high
o_rx_data  output  DATA_BITS  received character; valid while o_rx_vld=1, held until the next frame completes
o_rx_vld  output  1  one-i_clk-cycle pulse per completed frame
o_par_err  output  1  parity mismatch; qualified by o_rx_vld
o_frm_err  output  1  at least one stop bit sampled low; qualified by o_rx_vld
o_busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (i_rst=0, async): state IDLE; all counters 0; o_rx_data=0; o_rx_vld, o_par_err, o_frm_err, o_busy all 0. A reset mid-frame abandons the frame and produces no o_rx_vld.
- The state machine, sample counter, bit counter and stop counter advance only on cycles with i_baud_en=1. o_rx_vld is cleared on every other i_clk cycle.
- Sample counter: width $clog2(OVERSAMPLE). "Sample point" means the counter is 0 and i_baud_en=1.
- IDLE: on i_rx=0, load the counter with OVERSAMPLE/2-1 and go to START.
- START: at the sample point:
  - i_rx=0: load OVERSAMPLE-1, clear the bit counter, go to DATA.
  - i_rx=1: glitch; go to IDLE, no flags raised.
- DATA: at each sample point, shift the sample into o_rx_data[bit_cnt] and reload OVERSAMPLE-1.
  - After bit DATA_BITS-1, go to PARITY if PARITY_MODE!=0, otherwise to STOP.
  - o_rx_data updates only on bits of the current frame; partial bits are visible while o_busy=1.
- PARITY: sample once, reload, go to STOP.
  - Even mode: error when the XOR of data and parity bit is 1.
  - Odd mode: error when that XOR is 0.
- STOP: sample each stop bit at its sample point; any low sample sets the internal frm flag.
  - Between stop bits, reload OVERSAMPLE-1.
  - At the final stop bit's sample point: go to IDLE, and on the next i_clk edge assert o_rx_vld=1 together with o_par_err/o_frm_err for exactly one i_clk cycle.
- Latency: o_rx_vld rises 1 i_clk after the final stop-bit sample tick. The return to IDLE at mid-stop-bit gives half a bit of resync margin.
- Back-to-back frames: IDLE detects a new start bit on the first i_baud_en with i_rx=0 after returning. No dead time beyond that.
- A framing error still delivers the data with o_rx_vld=1.
- Break (all zeros, stop bit low) reports o_rx_data=0, o_frm_err=1. A continued low re-enters START immediately.
- i_baud_en stuck low: FSM freezes; no timeout.
- Internal flags clear on entry to START.

Optional Feature:
Macro UART_RX_MAJORITY_VOTE_EN.
- Defined: every bit sample (start confirm, data, parity, stop) is the 2-of-3 majority of i_rx captured on the three i_baud_en ticks at counter values 2, 1 and 0. The start-confirm load in IDLE stays at OVERSAMPLE/2-1. The vote register clears on every counter reload.
- Undefined: single sample at counter value 0; no vote logic.
- Frame timing and latency are identical in both builds.

Test Plan:
- Defaults (8N1, OS=16): send 0xA5, then 0x3C back-to-back -> two o_rx_vld pulses, o_rx_data=8'hA5 then 8'h3C, both error flags 0.
- DATA_BITS=7, PARITY_MODE=1, STOP_BITS=1: send 0x55 with parity bit 1 -> o_rx_data=7'h55, o_par_err=1 (correct bit 0 gives o_par_err=0).
- PARITY_MODE=2, STOP_BITS=2: send 0x0F with second stop bit low -> o_rx_vld=1, o_rx_data=8'h0F, o_frm_err=1, o_par_err=0.
- i_rx low for 4 ticks only -> START rejects, returns to IDLE; no o_rx_vld; o_busy low again after 8 ticks.
- Assert i_rst at bit 4 of 0xFF, release, then send 0x81 -> no pulse for the aborted frame, one pulse with 8'h81, all outputs 0 during reset.
- Macro defined: 1-tick high glitch at the centre of a 0 data bit in 0x00 -> o_rx_data=8'h00. Macro undefined: the same stimulus yields the corrupted bit set.

Source files
------------

// File: rtl/uart_rx_ctl_param.sv
// uart_rx_ctl_param: parametrised UART RX deframer. It handles 5-9 data bits,
// none/even/odd parity and 1-2 stop bits. It consumes synchronised RXD plus a
// per-bit oversampling tick.
// Ports: i_clk, i_rst (async low), i_baud_en, i_rx -> o_rx_data,
// o_rx_vld (1-cycle pulse), o_par_err, o_frm_err, o_busy.
// Build option UART_RX_MAJORITY_VOTE_EN: 2-of-3 vote on every bit sample.
module uart_rx_ctl_param #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_baud_en,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_vld,
  output logic                 o_par_err,
  output logic                 o_frm_err,
  output logic                 o_busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] C1   = CW'(1);
  localparam logic [BW-1:0] B1   = BW'(1);
  localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);

  if (PARITY_MODE < 0 || PARITY_MODE > 2 ||
      DATA_BITS < 5 || DATA_BITS > 9 ||
      STOP_BITS < 1 || STOP_BITS > 2 ||
      OVERSAMPLE < 8 || OVERSAMPLE > 32 ||
      (OVERSAMPLE % 2) != 0) begin : g_bad_cfg
    $error("uart_rx_ctl_param: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
  logic                 frm_q, frm_d;
  logic                 fin_q, fin_d;
  logic                 vld_q, vld_d;
  logic                 pe_q, pe_d;
  logic                 fe_q, fe_d;
  logic                 reload;
  logic                 bit_s;
  logic                 spt;
  logic                 last_stop;

  assign spt       = i_baud_en && (cnt_q == '0);
  assign last_stop = (STOP_BITS == 1) | stop_q;

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [CW-1:0] C2 = CW'(2);
  logic [1:0] vote_q, vote_d;
  // Samples at counter 2 and 1 are held; counter 0 votes with live i_rx.
  assign bit_s = (vote_q[1] & vote_q[0]) |
                 (vote_q[1] & i_rx) |
                 (vote_q[0] & i_rx);
`else
  assign bit_s = i_rx;
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_baud_en) begin
      unique case (state_q)
        S_IDLE:  if (!i_rx) state_d = S_START;
        S_START: if (spt) state_d = bit_s ? S_IDLE : S_DATA;
        S_DATA:  if (spt && bit_q == LAST)
                   state_d = (PARITY_MODE != 0) ? S_PAR : S_STOP;
        S_PAR:   if (spt) state_d = S_STOP;
        S_STOP:  if (spt && last_stop) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    bit_d  = bit_q;
    stop_d = stop_q;
    data_d = data_q;
    par_d  = par_q;
    perr_d = perr_q;
    frm_d  = frm_q;
    fin_d  = 1'b0;
    reload = 1'b0;
    // Frame result surfaces one cycle after the final stop sample.
    vld_d  = fin_q;
    pe_d   = fin_q & perr_q;
    fe_d   = fin_q & frm_q;
    if (i_baud_en) begin
      if (state_q != S_IDLE && cnt_q != '0) cnt_d = cnt_q - C1;
      unique case (state_q)
        S_IDLE: if (!i_rx) begin
          cnt_d  = HALF;
          par_d  = 1'b0;
          perr_d = 1'b0;
          frm_d  = 1'b0;
          reload = 1'b1;
        end
        S_START: if (spt && !bit_s) begin
          cnt_d  = FULL;
          bit_d  = '0;
          reload = 1'b1;
        end
        S_DATA: if (spt) begin
          data_d[bit_q] = bit_s;
          par_d  = par_q ^ bit_s;
          cnt_d  = FULL;
          bit_d  = bit_q + B1;
          stop_d = 1'b0;
          reload = 1'b1;
        end
        S_PAR: if (spt) begin
          if (PARITY_MODE == 1) perr_d = par_q ^ bit_s;
          else                  perr_d = ~(par_q ^ bit_s);
          cnt_d  = FULL;
          reload = 1'b1;
        end
        S_STOP: if (spt) begin
          if (!bit_s) frm_d = 1'b1;
          if (last_stop) begin
            fin_d = 1'b1;
          end else begin
            cnt_d  = FULL;
            stop_d = 1'b1;
            reload = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  always_comb begin
    vote_d = vote_q;
    if (i_baud_en && state_q != S_IDLE) begin
      if (cnt_q == C2) vote_d[1] = i_rx;
      if (cnt_q == C1) vote_d[0] = i_rx;
    end
    if (reload) vote_d = '0;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) vote_q <= '0;
    else        vote_q <= vote_d;
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_q  <= '0;
      bit_q  <= '0;
      stop_q <= 1'b0;
      data_q <= '0;
      par_q  <= 1'b0;
      perr_q <= 1'b0;
      frm_q  <= 1'b0;
      fin_q  <= 1'b0;
      vld_q  <= 1'b0;
      pe_q   <= 1'b0;
      fe_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      stop_q <= stop_d;
      data_q <= data_d;
      par_q  <= par_d;
      perr_q <= perr_d;
      frm_q  <= frm_d;
      fin_q  <= fin_d;
      vld_q  <= vld_d;
      pe_q   <= pe_d;
      fe_q   <= fe_d;
    end
  end

  always_comb begin
    o_busy    = (state_q != S_IDLE);
    o_rx_data = data_q;
    o_rx_vld  = vld_q;
    o_par_err = pe_q;
    o_frm_err = fe_q;
  end

endmodule

// File: tb/tb_uart_rx_ctl_param.sv
// tb_uart_rx_ctl_param: directed frames into three configurations of
// uart_rx_ctl_param with a queue of expected frames per instance.
module tb_uart_rx_ctl_param;

  logic clk = 1'b0;
  logic rst_n;
  logic baud;
  logic rx0, rx1, rx2;

  logic [7:0] d0;
  logic       v0, pe0, fe0, b0;
  logic [6:0] d1;
  logic       v1, pe1, fe1, b1;
  logic [7:0] d2;
  logic       v2, pe2, fe2, b2;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [8:0] data;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t e0, e1, e2;

  logic bh1 = 1'b0;
  logic bh2 = 1'b0;

  always #5 clk = ~clk;

  uart_rx_ctl_param u0 (
    .i_clk(clk), .i_rst(rst_n), .i_baud_en(baud), .i_rx(rx0),
    .o_rx_data(d0), .o_rx_vld(v0), .o_par_err(pe0),
    .o_frm_err(fe0), .o_busy(b0)
  );

  uart_rx_ctl_param #(
    .DATA_BITS(7), .OVERSAMPLE(16), .PARITY_MODE(1), .STOP_BITS(1)
  ) u1 (
    .i_clk(clk), .i_rst(rst_n), .i_baud_en(baud), .i_rx(rx1),
    .o_rx_data(d1), .o_rx_vld(v1), .o_par_err(pe1),
    .o_frm_err(fe1), .o_busy(b1)
  );

  uart_rx_ctl_param #(
    .DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(2), .STOP_BITS(2)
  ) u2 (
    .i_clk(clk), .i_rst(rst_n), .i_baud_en(baud), .i_rx(rx2),
    .o_rx_data(d2), .o_rx_vld(v2), .o_par_err(pe2),
    .o_frm_err(fe2), .o_busy(b2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One baud tick every 4 clocks, changed on the falling edge.
  initial begin
    int ph;
    ph   = 0;
    baud = 1'b0;
    forever begin
      @(negedge clk);
      baud = (ph == 0);
      ph   = (ph + 1) % 4;
    end
  end

  // bh2 holds the tick value seen two rising edges back.
  always @(posedge clk) begin
    bh2 <= bh1;
    bh1 <= baud;
  end

  always @(negedge clk) begin
    if (v0) begin
      chk("lat0", bh2, 1);
      if (q0.size() == 0) chk("spurious0", q0.size(), 1);
      else begin
        e0 = q0.pop_front();
        chk("data0", d0, e0.data);
        chk("perr0", pe0, e0.pe);
        chk("ferr0", fe0, e0.fe);
      end
    end
    if (v1) begin
      chk("lat1", bh2, 1);
      if (q1.size() == 0) chk("spurious1", q1.size(), 1);
      else begin
        e1 = q1.pop_front();
        chk("data1", d1, e1.data);
        chk("perr1", pe1, e1.pe);
        chk("ferr1", fe1, e1.fe);
      end
    end
    if (v2) begin
      chk("lat2", bh2, 1);
      if (q2.size() == 0) chk("spurious2", q2.size(), 1);
      else begin
        e2 = q2.pop_front();
        chk("data2", d2, e2.data);
        chk("perr2", pe2, e2.pe);
        chk("ferr2", fe2, e2.fe);
      end
    end
  end

  // A window of 4 clocks contains exactly one baud tick.
  task automatic win(input int n);
    repeat (n * 4) @(negedge clk);
  endtask

  task automatic drv(input int w, input logic v);
    case (w)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  task automatic send(input int w, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      drv(w, bits[i]);
      win(16);
    end
    drv(w, 1'b1);
  endtask

  task automatic push(input int w, input logic [8:0] d,
                      input logic pe, input logic fe);
    exp_t e;
    e.data = d;
    e.pe   = pe;
    e.fe   = fe;
    case (w)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_data"}, d0, 0);
    chk({tag, "_vld"}, v0, 0);
    chk({tag, "_perr"}, pe0, 0);
    chk({tag, "_ferr"}, fe0, 0);
    chk({tag, "_busy"}, b0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] gexp;
    rst_n = 1'b0;
    rx0 = 1'b1;
    rx1 = 1'b1;
    rx2 = 1'b1;
    repeat (3) @(negedge clk);
    chk_rst("rst");
    rst_n = 1'b1;
    win(2);

    // 8N1 back-to-back frames
    push(0, 9'hA5, 1'b0, 1'b0);
    push(0, 9'h3C, 1'b0, 1'b0);
    send(0, {1'b1, 8'hA5, 1'b0}, 10);
    send(0, {1'b1, 8'h3C, 1'b0}, 10);
    win(4);
    chk("hold0", d0, 8'h3C);
    chk("idle0", b0, 0);

    // 7E1: wrong, right, and a three-ones value
    push(1, 9'h55, 1'b1, 1'b0);
    send(1, {1'b1, 1'b1, 7'h55, 1'b0}, 10);
    push(1, 9'h55, 1'b0, 1'b0);
    send(1, {1'b1, 1'b0, 7'h55, 1'b0}, 10);
    push(1, 9'h13, 1'b0, 1'b0);
    send(1, {1'b1, 1'b1, 7'h13, 1'b0}, 10);
    win(4);

    // 8O2: good, bad parity, second stop low
    push(2, 9'h0F, 1'b0, 1'b0);
    send(2, {1'b1, 1'b1, 1'b1, 8'h0F, 1'b0}, 12);
    push(2, 9'h0F, 1'b1, 1'b0);
    send(2, {1'b1, 1'b1, 1'b0, 8'h0F, 1'b0}, 12);
    push(2, 9'h0F, 1'b0, 1'b1);
    send(2, {1'b0, 1'b1, 1'b1, 8'h0F, 1'b0}, 12);
    win(16);
    chk("idle2", b2, 0);

    // Short start pulse is rejected
    drv(0, 1'b0);
    win(1);
    chk("glitch_busy1", b0, 1);
    win(3);
    drv(0, 1'b1);
    win(4);
    chk("glitch_busy8", b0, 1);
    win(1);
    chk("glitch_idle9", b0, 0);
    win(4);

    // Reset in bit 4 of 0xFF, then a clean 0x81
    drv(0, 1'b0);
    win(16);
    drv(0, 1'b1);
    win(16 * 4 + 8);
    chk("mid_busy", b0, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_rst("midrst");
    win(2);
    rst_n = 1'b1;
    win(4);
    push(0, 9'h81, 1'b0, 1'b0);
    send(0, {1'b1, 8'h81, 1'b0}, 10);
    win(4);

    // One-tick high glitch at the centre of data bit 3 of 0x00
`ifdef UART_RX_MAJORITY_VOTE_EN
    gexp = 9'h000;
`else
    gexp = 9'h008;
`endif
    push(0, gexp, 1'b0, 1'b0);
    drv(0, 1'b0);
    win(16 + 48 + 8);
    drv(0, 1'b1);
    win(1);
    drv(0, 1'b0);
    win(7 + 64);
    drv(0, 1'b1);
    win(16);
    win(8);

    chk("pending0", q0.size(), 0);
    chk("pending1", q1.size(), 0);
    chk("pending2", q2.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
